switch_input: RTL and testbench

SWITCH_INPUT -- requirements
Module: switch_input

---
 rtl/switch_input.sv | 157 +++++++++++++++
 tb/tb_switch_input.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_input.sv
// -----------------------------------------------------------------------------
// switch_input
//
// Memory-mapped input port for 16 board switches and one confirm button.
// Each raw pin passes through a 2-flop synchronizer. The synchronized value
// then feeds a per-bit stable register, with optional debouncing. A rising
// edge on the stable button bit sets a sticky pending flag. A button-status
// read clears that flag.
//
// Configuration macro: SWITCH_DEBOUNCE_EN
//   defined   : each bit has a saturating counter. The stable value follows
//               the synchronized bit only after the two have differed for
//               DEBOUNCE_CYCLES consecutive clocks.
//   undefined : the stable value is reloaded from the synchronizer on every
//               clock, so a pin change reaches it in 3 clocks.
//               DEBOUNCE_CYCLES has no effect in this build.
//
// Ports
//   sw_clk       in   1   system clock, rising edge
//   ledrst       in   1   asynchronous active-low reset
//   SWCtrl       in   1   peripheral select
//   swread       in   1   read strobe
//   swaddr       in   2   00 all switches, 10 upper byte, 11 lower byte,
//                         01 button status {stable_btn, btn_pending}
//   sw_in        in   16  raw switch pins (asynchronous)
//   btn_in       in   1   raw confirm button pin (asynchronous)
//   swrdata      out  32  registered read data (1-clock latency)
//   btn_pending  out  1   sticky "button pressed, not yet read" flag
// -----------------------------------------------------------------------------
module switch_input #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd200000
) (
  input  logic        sw_clk,
  input  logic        ledrst,
  input  logic        SWCtrl,
  input  logic        swread,
  input  logic [1:0]  swaddr,
  input  logic [15:0] sw_in,
  input  logic        btn_in,
  output logic [31:0] swrdata,
  output logic        btn_pending
);

  localparam int NUM_IN = 17;
  localparam int BTN    = 16;   // button occupies the top bit of the input vector

  logic [NUM_IN-1:0] meta_d,   meta_q;
  logic [NUM_IN-1:0] sync_d,   sync_q;
  logic [NUM_IN-1:0] stable_d, stable_q;
  logic              btn_prev_d, btn_prev_q;
  logic              pend_d,     pend_q;
  logic [31:0]       rdata_d,    rdata_q;
  logic              rd_en, rd_clr, btn_rise;

  // Synchronizer stage: raw pins -> meta -> sync
  always_comb begin
    meta_d = {btn_in, sw_in};
    sync_d = meta_q;
  end

`ifdef SWITCH_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 20'd1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 20'd1);

  logic [CNT_W-1:0] cnt_d [NUM_IN];
  logic [CNT_W-1:0] cnt_q [NUM_IN];

  // Saturating increment: holds at CNT_MAX instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Debounce stage: a bit must disagree with its stable value for
  // DEBOUNCE_CYCLES consecutive clocks before the stable value follows.
  // Any clock of agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_IN; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = sat_inc(cnt_q[i]);
        end
      end
    end
  end

  always_ff @(posedge sw_clk or negedge ledrst) begin
    if (!ledrst) begin
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  // The debounce length has no role when the stable value simply tracks
  // the synchronizer; keep the parameter for a uniform instance interface.
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = (DEBOUNCE_CYCLES != 20'd0);

  // Stable stage: tracks the synchronizer output every clock.
  always_comb begin
    stable_d = sync_q;
  end
`endif

  // Control / read stage
  always_comb begin
    rd_en      = SWCtrl & swread;
    rd_clr     = rd_en & (swaddr == 2'b01);
    btn_rise   = stable_q[BTN] & ~btn_prev_q;
    btn_prev_d = stable_q[BTN];

    // A press seen in the same clock as the clearing read wins.
    pend_d = pend_q;
    if (btn_rise) begin
      pend_d = 1'b1;
    end else if (rd_clr) begin
      pend_d = 1'b0;
    end

    // Button-status reads return the flag value from before the clear.
    rdata_d = rdata_q;
    if (rd_en) begin
      case (swaddr)
        2'b00: rdata_d = {16'h0, stable_q[15:0]};
        2'b10: rdata_d = {24'h0, stable_q[15:8]};
        2'b11: rdata_d = {24'h0, stable_q[7:0]};
        2'b01: rdata_d = {30'h0, stable_q[BTN], pend_q};
      endcase
    end
  end

  always_ff @(posedge sw_clk or negedge ledrst) begin
    if (!ledrst) begin
      meta_q     <= '0;
      sync_q     <= '0;
      stable_q   <= '0;
      btn_prev_q <= 1'b0;
      pend_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      stable_q   <= stable_d;
      btn_prev_q <= btn_prev_d;
      pend_q     <= pend_d;
      rdata_q    <= rdata_d;
    end
  end

  assign swrdata     = rdata_q;
  assign btn_pending = pend_q;

endmodule

// File: tb/tb_switch_input.sv
module tb_switch_input;

`ifdef SWITCH_DEBOUNCE_EN
  localparam int DB     = 4;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int DB     = 1;   // stable follows sync after one clock
  localparam bit DEB_ON = 1'b0;
`endif

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        swctrl = 1'b0;
  logic        swread = 1'b0;
  logic [1:0]  swaddr = 2'b00;
  logic [15:0] sw_in  = 16'h0;
  logic        btn_in = 1'b0;
  logic [31:0] swrdata;
  logic        btn_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  switch_input #(.DEBOUNCE_CYCLES(20'd4)) dut (
    .sw_clk      (clk),
    .ledrst      (rst_n),
    .SWCtrl      (swctrl),
    .swread      (swread),
    .swaddr      (swaddr),
    .sw_in       (sw_in),
    .btn_in      (btn_in),
    .swrdata     (swrdata),
    .btn_pending (btn_pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Pins reach the "synchronized" view two clocks late; a
  // stable bit flips when the last DB synchronized samples all disagree with it.
  // ---------------------------------------------------------------------------
  logic [16:0] m_dly1 = '0, m_dly2 = '0, m_stable = '0, nstable;
  logic        m_prev = 1'b0, m_pend = 1'b0, m_rise, all_diff, m_en;
  logic [31:0] m_rdata = '0;
  logic [16:0] hist[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dly1 = '0; m_dly2 = '0; m_stable = '0;
      m_prev = 1'b0; m_pend = 1'b0; m_rdata = '0;
      hist.delete();
    end else begin
      hist.push_back(m_dly2);
      if (hist.size() > DB) void'(hist.pop_front());
      nstable = m_stable;
      if (hist.size() == DB) begin
        for (int b = 0; b < 17; b++) begin
          all_diff = 1'b1;
          foreach (hist[k]) if (hist[k][b] == m_stable[b]) all_diff = 1'b0;
          if (all_diff) nstable[b] = ~m_stable[b];
        end
      end
      m_rise = m_stable[16] && !m_prev;
      m_en   = swctrl && swread;
      if (m_en) begin
        case (swaddr)
          2'b00: m_rdata = {16'h0, m_stable[15:0]};
          2'b10: m_rdata = {24'h0, m_stable[15:8]};
          2'b11: m_rdata = {24'h0, m_stable[7:0]};
          default: m_rdata = {30'h0, m_stable[16], m_pend};
        endcase
      end
      if (m_rise) m_pend = 1'b1;
      else if (m_en && swaddr == 2'b01) m_pend = 1'b0;
      m_prev   = m_stable[16];
      m_stable = nstable;
      m_dly2   = m_dly1;
      m_dly1   = {btn_in, sw_in};
    end
  end

  always @(negedge clk) begin
    check("mdl_rdata", swrdata, m_rdata);
    check("mdl_pend", {31'b0, btn_pending}, {31'b0, m_pend});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        ctrl;
    logic        rd;
    logic [1:0]  addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];
  logic seen;
  int   sw_hold, bt_hold;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 2'b10, 32'h000000A5};
    vecs[1] = '{1'b1, 1'b1, 2'b11, 32'h000000C3};
    vecs[2] = '{1'b0, 1'b1, 2'b00, 32'h000000C3};
    vecs[3] = '{1'b1, 1'b0, 2'b10, 32'h000000C3};
    vecs[4] = '{1'b1, 1'b1, 2'b00, 32'h0000A5C3};
    vecs[5] = '{1'b0, 1'b0, 2'b11, 32'h0000A5C3};
    vecs[6] = '{1'b1, 1'b1, 2'b01, 32'h00000000};
    vecs[7] = '{1'b1, 1'b1, 2'b10, 32'h000000A5};

    // Reset held with active inputs: everything must stay zero.
    sw_in = 16'hFFFF; btn_in = 1'b1; swctrl = 1'b1; swread = 1'b1; swaddr = 2'b00;
    clocks(3);
    check("rst_rdata", swrdata, 32'h0);
    check("rst_pend", {31'b0, btn_pending}, 32'h0);

    // Release reset with a switch pattern held; read all switches.
    rst_n = 1'b1; sw_in = 16'hA5C3; btn_in = 1'b0;
    clocks(2 + DB);
    check("lat_before", swrdata, 32'h0);
    clocks(1);
    check("lat_after", swrdata, 32'h0000A5C3);

    // Read selector / hold behaviour.
    for (int v = 0; v < 8; v++) begin
      swctrl = vecs[v].ctrl; swread = vecs[v].rd; swaddr = vecs[v].addr;
      clocks(1);
      check($sformatf("vec%0d", v), swrdata, vecs[v].exp);
    end

    // Glitch rejection on bit 0.
    swctrl = 1'b1; swread = 1'b1; swaddr = 2'b00; sw_in = 16'hA5C2;
    clocks(10);
    check("glitch_base", swrdata, 32'h0000A5C2);
    seen = 1'b0; sw_in[0] = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      seen |= swrdata[0];
      if (i == 3) sw_in[0] = 1'b0;
    end
    check("short_pulse", {31'b0, seen}, {31'b0, !DEB_ON});
    seen = 1'b0; sw_in[0] = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      seen |= swrdata[0];
      if (i == 6) sw_in[0] = 1'b0;
    end
    check("long_pulse", {31'b0, seen}, 32'h1);
    check("pulse_end", swrdata, 32'h0000A5C2);

    // Button press, then clearing read.
    swctrl = 1'b0; swread = 1'b0; btn_in = 1'b1;
    clocks(10);
    check("btn_set", {31'b0, btn_pending}, 32'h1);
    swctrl = 1'b1; swread = 1'b1; swaddr = 2'b01;
    clocks(1);
    swctrl = 1'b0;
    check("btn_read", swrdata, 32'h00000003);
    check("btn_clear", {31'b0, btn_pending}, 32'h0);
    btn_in = 1'b0;
    clocks(10);
    check("btn_release", {31'b0, btn_pending}, 32'h0);

    // Press edge coincident with a clearing read: set wins.
    btn_in = 1'b1;
    clocks(2 + DB);
    swctrl = 1'b1; swread = 1'b1; swaddr = 2'b01;
    clocks(1);
    swctrl = 1'b0;
    check("coinc_pend", {31'b0, btn_pending}, 32'h1);
    check("coinc_rdata", swrdata, 32'h00000002);
    swctrl = 1'b1;
    clocks(1);
    swctrl = 1'b0;
    check("coinc_read", swrdata, 32'h00000003);
    check("coinc_clear", {31'b0, btn_pending}, 32'h0);

    // Asynchronous reset mid-debounce.
    btn_in = 1'b0;
    clocks(2 + DB + 2);
    btn_in = 1'b1;
    clocks(3 + DB + 1);
    check("pre_rst_pend", {31'b0, btn_pending}, 32'h1);
    check("pre_rst_rdata", swrdata, 32'h00000003);
    sw_in = 16'h1234;
    clocks(2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rdata", swrdata, 32'h0);
    check("arst_pend", {31'b0, btn_pending}, 32'h0);
    clocks(2);
    rst_n = 1'b1; swctrl = 1'b1; swread = 1'b1; swaddr = 2'b00;
    clocks(2 + DB);
    check("post_rst_before", swrdata, 32'h0);
    clocks(1);
    check("post_rst_after", swrdata, 32'h00001234);

    // Randomized traffic against the reference model.
    sw_hold = 0; bt_hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (sw_hold == 0) begin
        sw_in   = 16'($urandom);
        sw_hold = int'($urandom_range(1, 9));
      end
      sw_hold--;
      if (bt_hold == 0) begin
        btn_in  = 1'($urandom_range(0, 1));
        bt_hold = int'($urandom_range(1, 9));
      end
      bt_hold--;
      swctrl = ($urandom_range(0, 3) != 0);
      swread = ($urandom_range(0, 3) != 0);
      swaddr = 2'($urandom_range(0, 3));
      if (i == 200) begin
        #3 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
